// File: rtl/instr_mem_pkg.sv
// rtl/instr_mem_pkg.sv - shared constants and state encoding for instruction/data memories
package instr_mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RESP = 2'b10
  } state_t;

  localparam int WORD_W          = 32;
  localparam int DEFAULT_LATENCY = 4;

endpackage

// File: rtl/instr_mem_array.sv
// rtl/instr_mem_array.sv - byte-wide storage with one write port and a little-endian word read
module mem_array_byte
  import instr_mem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_word
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // A byte being written this cycle is forwarded so a same-edge read sees the new value.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [ADDR_W-1:0] lane_addr;
    assign lane_addr = rd_addr + ADDR_W'(i);
    assign rd_word[8*i +: 8] = (wr_en && (wr_addr == lane_addr)) ? wr_data : mem[lane_addr];
  end

endmodule

// File: rtl/instr_mem.sv
// rtl/instr_mem.sv - multi-cycle instruction fetch responder with byte load port
module instr_mem
  import instr_mem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              READ,
  input  logic [ADDR_W-1:0] ADDRESS,
  output logic [WORD_W-1:0] READDATA,
  output logic              BUSYWAIT,
  input  logic              LOAD_EN,
  input  logic [ADDR_W-1:0] LOAD_ADDR,
  input  logic [7:0]        LOAD_DATA
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t            state, state_next;
  logic [3:0]        count;
  logic [ADDR_W-1:0] lat_addr;
  logic [ADDR_W-1:0] req_addr;
  logic              addr_changed;
  logic              start_fetch;
  logic [WORD_W-1:0] mem_word;

  assign req_addr     = ADDRESS & ~ADDR_W'(3);
  assign addr_changed = (req_addr != lat_addr);
  assign start_fetch  = READ && ((state == S_IDLE) || ((state == S_WAIT) && addr_changed));

  mem_array_byte #(.ADDR_W(ADDR_W)) u_array (
    .clk     (CLK),
    .wr_en   (LOAD_EN),
    .wr_addr (LOAD_ADDR),
    .wr_data (LOAD_DATA),
    .rd_addr (lat_addr),
    .rd_word (mem_word)
  );

  always_comb begin
    state_next = state;
    BUSYWAIT   = 1'b0;
    case (state)
      S_IDLE: begin
        if (READ) begin
          BUSYWAIT   = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        BUSYWAIT = READ;
        if (!READ)                             state_next = S_IDLE;
        else if (!addr_changed && count == '0) state_next = S_RESP;
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= S_IDLE;
      count    <= '0;
      lat_addr <= '0;
      READDATA <= '0;
    end else begin
      state <= state_next;
      if (start_fetch) begin
        lat_addr <= req_addr;
        count    <= CNT_INIT;
      end else if ((state == S_WAIT) && (count != '0)) begin
        count <= count - 4'd1;
      end
      if (state_next == S_RESP) READDATA <= mem_word;
    end
  end

endmodule

// File: tb/tb_instr_mem.sv
// tb/tb_instr_mem.sv - randomized self-checking bench for instr_mem at LATENCY 4 and 1
module tb_instr_mem;

  localparam int AW = 10;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          rd    [2];
  logic [AW-1:0] addr  [2];
  logic [31:0]   rdata [2];
  logic          busy  [2];
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [7:0]    load_data;

  logic [7:0]  ref_mem [1024];
  logic [31:0] last [2];
  int          lat  [2];
  int          checks = 0;
  int          passed = 0;

  always #5 CLK = ~CLK;

  instr_mem #(.ADDR_W(AW), .LATENCY(4)) dut4 (
    .CLK(CLK), .RESET(RESET), .READ(rd[0]), .ADDRESS(addr[0]),
    .READDATA(rdata[0]), .BUSYWAIT(busy[0]),
    .LOAD_EN(load_en), .LOAD_ADDR(load_addr), .LOAD_DATA(load_data)
  );

  instr_mem #(.ADDR_W(AW), .LATENCY(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .READ(rd[1]), .ADDRESS(addr[1]),
    .READDATA(rdata[1]), .BUSYWAIT(busy[1]),
    .LOAD_EN(load_en), .LOAD_ADDR(load_addr), .LOAD_DATA(load_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_word(input logic [AW-1:0] a);
    logic [AW-1:0] b;
    b = {a[AW-1:2], 2'b00};
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  // Called at a negedge; the byte commits at the following posedge.
  task automatic load_byte(input logic [AW-1:0] a, input logic [7:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    ref_mem[a] = d;
    @(negedge CLK);
    load_en = 1'b0;
  endtask

  // Starts at a negedge with the DUT idle (or one cycle past RESP, READ still high).
  // Leaves READ high at the negedge after the response cycle so fetches can chain.
  task automatic fetch(input int d, input logic [AW-1:0] a, input logic [AW-1:0] a2,
                       input int chg_at, input bit loads, input string tag);
    int            n     = 0;
    int            exp_n = lat[d] + 1;
    logic [AW-1:0] cur   = a;
    logic [AW-1:0] ba;
    logic [31:0]   exp_w;
    addr[d] = a;
    rd[d]   = 1'b1;
    #1;
    check({tag, "_busy_req"}, busy[d], 1);
    while (n <= 64) begin
      @(posedge CLK);
      @(negedge CLK);
      n++;
      load_en = 1'b0;
      if (!busy[d]) break;
      check({tag, "_hold"}, rdata[d], last[d]);
      if (n == chg_at) begin
        addr[d] = a2;
        cur     = a2;
        exp_n   = n + 1 + lat[d];
      end
      if (loads && $urandom_range(0, 2) == 0) begin
        ba        = {cur[AW-1:2], 2'($urandom_range(0, 3))};
        load_en   = 1'b1;
        load_addr = ba;
        load_data = 8'($urandom);
        ref_mem[ba] = load_data;
      end
    end
    exp_w = ref_word(cur);
    check({tag, "_latency"}, n, exp_n);
    check({tag, "_data"}, rdata[d], exp_w);
    last[d] = exp_w;
    @(negedge CLK);
    check({tag, "_one_resp"}, busy[d], 1);
  endtask

  task automatic idle(input int d);
    rd[d] = 1'b0;
    @(negedge CLK);
  endtask

  task automatic abort_fetch(input int d, input logic [AW-1:0] a, input int k, input string tag);
    addr[d] = a;
    rd[d]   = 1'b1;
    repeat (k) @(negedge CLK);
    rd[d] = 1'b0;
    #1;
    check({tag, "_busy_now"}, busy[d], 0);
    @(negedge CLK);
    check({tag, "_busy_next"}, busy[d], 0);
    check({tag, "_data_kept"}, rdata[d], last[d]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int            d;
    int            chg;
    logic [AW-1:0] a;
    lat[0] = 4; lat[1] = 1;
    last[0] = '0; last[1] = '0;
    RESET = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    rd[0] = 1'b0; rd[1] = 1'b0; addr[0] = '0; addr[1] = '0;
    repeat (3) @(negedge CLK);
    check("rst_busy4", busy[0], 0);
    check("rst_data4", rdata[0], 0);
    check("rst_busy1", busy[1], 0);
    check("rst_data1", rdata[1], 0);
    RESET = 1'b0;

    for (int i = 0; i < 1024; i++) load_byte(AW'(i), 8'($urandom));
    load_byte(10'h000, 8'h05);
    load_byte(10'h001, 8'h01);
    load_byte(10'h002, 8'h00);
    load_byte(10'h003, 8'h00);

    fetch(0, 10'h000, 10'h000, 0, 1'b0, "first");
    check("first_const", last[0], 32'h0000_0105);
    fetch(0, 10'h004, 10'h000, 0, 1'b0, "b2b_4");
    fetch(0, 10'h008, 10'h000, 0, 1'b0, "b2b_8");
    idle(0);
    fetch(0, 10'h006, 10'h000, 0, 1'b0, "misalign");
    idle(0);
    fetch(0, 10'h3FC, 10'h000, 0, 1'b0, "top_word");
    idle(0);
    fetch(0, 10'h010, 10'h020, 2, 1'b0, "addr_chg");
    idle(0);
    abort_fetch(0, 10'h050, 2, "abort");
    fetch(0, 10'h054, 10'h000, 0, 1'b0, "after_abort");
    idle(0);

    addr[0] = 10'h080;
    rd[0]   = 1'b1;
    repeat (2) @(negedge CLK);
    RESET     = 1'b1;
    load_en   = 1'b1;
    load_addr = 10'h101;
    load_data = 8'($urandom);
    ref_mem[10'h101] = load_data;
    @(negedge CLK);
    RESET   = 1'b0;
    load_en = 1'b0;
    check("rst_mid_data", rdata[0], 0);
    rd[0] = 1'b0;
    #1;
    check("rst_mid_busy", busy[0], 0);
    last[0] = '0;
    last[1] = '0;
    @(negedge CLK);
    fetch(0, 10'h100, 10'h000, 0, 1'b0, "after_rst");
    idle(0);

    for (int i = 0; i < 4; i++) load_byte(AW'(10'h040 + i), 8'($urandom));
    fetch(1, 10'h040, 10'h000, 0, 1'b0, "lat1");
    idle(1);

    for (int it = 0; it < 60; it++) begin
      d = int'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        abort_fetch(d == 1 ? 0 : 0, AW'($urandom), int'($urandom_range(1, 3)), "rnd_abort");
      end
      for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
        a   = AW'($urandom);
        chg = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, lat[d])) : 0;
        fetch(d, a, a + AW'(4 * $urandom_range(1, 255)), chg, 1'b1, "rnd");
      end
      idle(d);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
